// File: rtl/instr_mem_loader.sv
// Packs decoded instruction fields into 32-bit words, writes them sequentially into instruction
// memory from address 0, then raises the processor enable. Optional feature macro: LOADER_CHECKSUM_EN.
//
// state | meaning
// LOAD  | accepting field bundles
// EXT   | writing the main word that follows an immediate-extension prefix
// RUN   | program loaded, processor enabled, input ignored

module instr_mem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [3:0]  EXT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [3:0]        rd,
  input  logic [31:0]       imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              en,
  output logic              full,
  output logic              ovf,
  output logic [ADDR_W:0]   words_written
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              en_q, en_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W:0]   words_written_q, words_written_d;
  logic [31:0]       pend_word_q, pend_word_d;
  logic              pend_last_q, pend_last_d;

  logic              xfer;
  logic              imm_long;
  logic              do_write;
  logic [31:0]       main_word;
  logic [31:0]       prefix_word;
  logic [31:0]       write_word;
  logic [ADDR_W:0]   words_inc;

  assign in_ready    = (state_q == ST_LOAD) && !full_q && !rst;
  assign xfer        = in_valid && in_ready;
  // an immediate fits the 16-bit field only when it is the sign extension of its low half
  assign imm_long    = !((&imm[31:15]) || !(|imm[31:15]));
  assign main_word   = {opcode, rs, rt, rd, imm[15:0]};
  assign prefix_word = {EXT_OPCODE, 12'h000, imm[31:16]};
  assign words_inc   = words_written_q + ONE;

  always_comb begin
    state_d         = state_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    en_d            = en_q;
    full_d          = full_q;
    ovf_d           = ovf_q;
    words_written_d = words_written_q;
    pend_word_d     = pend_word_q;
    pend_last_d     = pend_last_q;
    do_write        = 1'b0;
    write_word      = 32'h0000_0000;

    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (!imm_long) begin
            do_write   = 1'b1;
            write_word = main_word;
            state_d    = in_last ? ST_RUN : ST_LOAD;
          end else if (words_written_q == LAST_SLOT) begin
            // the pair cannot be split across the end of memory, so the whole instruction is dropped
            ovf_d   = 1'b1;
            full_d  = 1'b1;
            state_d = in_last ? ST_RUN : ST_LOAD;
          end else begin
            do_write    = 1'b1;
            write_word  = prefix_word;
            pend_word_d = main_word;
            pend_last_d = in_last;
            state_d     = ST_EXT;
          end
        end
      end
      ST_EXT: begin
        do_write   = 1'b1;
        write_word = pend_word_q;
        state_d    = pend_last_q ? ST_RUN : ST_LOAD;
      end
      ST_RUN: begin
        en_d = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    if (do_write) begin
      mem_we_d        = 1'b1;
      mem_addr_d      = words_written_q[ADDR_W-1:0];
      mem_wdata_d     = write_word;
      words_written_d = words_inc;
      full_d          = (words_inc == DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_LOAD;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 32'h0000_0000;
      en_q            <= 1'b0;
      full_q          <= 1'b0;
      ovf_q           <= 1'b0;
      words_written_q <= '0;
      pend_word_q     <= 32'h0000_0000;
      pend_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      en_q            <= en_d;
      full_q          <= full_d;
      ovf_q           <= ovf_d;
      words_written_q <= words_written_d;
      pend_word_q     <= pend_word_d;
      pend_last_q     <= pend_last_d;
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign en            = en_q;
  assign full          = full_q;
  assign ovf           = ovf_q;
  assign words_written = words_written_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // accumulated together with the write decision so the sum already includes the word on mem_wdata
  always_comb begin
    checksum_d = checksum_q;
    if (do_write) begin
      checksum_d = checksum_q + write_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 32'h0000_0000;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus randomized programs
// compared against a word-list reference model.

module tb_instr_mem_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [3:0]    opcode = 4'h0, rs = 4'h0, rt = 4'h0, rd = 4'h0;
  logic [31:0]   imm = 32'h0;
  logic          in_ready, mem_we, en, full, ovf;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   words_written;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_mem_loader #(.ADDR_W(AW), .EXT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .en(en),
    .full(full), .ovf(ovf), .words_written(words_written)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // observed writes
  int          mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  int          en_cyc = -1;
  int          overlap = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mon_addr.push_back(int'(mem_addr));
      mon_data.push_back(mem_wdata);
      mon_cyc.push_back(cyc);
    end
    if (en === 1'b1 && en_cyc < 0) en_cyc = cyc;
    if (en === 1'b1 && mem_we === 1'b1) overlap++;
  end

  // reference model: list of expected writes and loader bookkeeping
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  int          m_ww = 0;
  bit          m_ovf = 0;
  int          m_en_cyc = -1;

  function automatic bit long_imm(logic [31:0] v);
    int s;
    s = v;
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [31:0] rand_imm(bit want_long);
    logic [31:0] v;
    logic [31:0] r;
    int k;
    k = $urandom_range(0, 5);
    r = $urandom;
    if (want_long) begin
      case (k)
        0: v = 32'h0000_8000;
        1: v = 32'hFFFF_7FFF;
        default: begin
          v = r;
          if (!long_imm(v)) v = v ^ 32'h4000_0000;
        end
      endcase
    end else begin
      case (k)
        0: v = 32'h0000_7FFF;
        1: v = 32'hFFFF_8000;
        2: v = 32'h0000_0000;
        default: v = {{17{r[15]}}, r[14:0]};
      endcase
    end
    return v;
  endfunction

  task automatic clear_tracking();
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    en_cyc = -1; overlap = 0;
    m_ww = 0; m_ovf = 0; m_en_cyc = -1;
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    clear_tracking();
  endtask

  // waits for in_ready, transfers one bundle and updates the model with the expected writes
  task automatic send(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] d, input logic [31:0] im, input bit last, input int gap);
    int budget;
    int x;
    logic [31:0] mainw;
    budget = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    opcode = op; rs = s1; rt = s2; rd = d; imm = im; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    x = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    mainw = {op, s1, s2, d, im[15:0]};
    if (!long_imm(im)) begin
      exp_addr.push_back(m_ww); exp_data.push_back(mainw); exp_cyc.push_back(x);
      m_ww += 1;
      if (last) m_en_cyc = x + 1;
    end else if (DEPTH - m_ww == 1) begin
      m_ovf = 1;
      if (last) m_en_cyc = x + 1;
    end else begin
      exp_addr.push_back(m_ww);     exp_data.push_back({4'hF, 12'h000, im[31:16]}); exp_cyc.push_back(x);
      exp_addr.push_back(m_ww + 1); exp_data.push_back(mainw);                      exp_cyc.push_back(x + 1);
      m_ww += 2;
      if (last) m_en_cyc = x + 2;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; imm = 32'h1234_5678;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, mem_we, en, full, ovf} !== 5'b00000) begin
      fails++; $display("FAIL reset_flags: got %b required 00000", {in_ready, mem_we, en, full, ovf});
    end
    tests++;
    if (mem_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0h required 0", mem_addr); end
    tests++;
    if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    tests++;
    if (words_written !== '0) begin fails++; $display("FAIL reset_ww: got %0d required 0", words_written); end
`ifdef LOADER_CHECKSUM_EN
    tests++;
    if (checksum !== 32'h0) begin fails++; $display("FAIL reset_checksum: got %h required 0", checksum); end
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    clear_tracking();
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
  endtask

  task automatic test_short_load();
    do_reset(2);
    send(4'd1, 4'd2, 4'd3, 4'd4, 32'd5, 1'b1, 0);
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_wdata !== 32'h1234_0005 || en !== 1'b0) begin
      fails++; $display("FAIL short_write: we=%b addr=%0d data=%h en=%b required 1/0/12340005/0",
                        mem_we, mem_addr, mem_wdata, en);
    end
    @(negedge clk);
    tests++;
    if (en !== 1'b1 || words_written !== 4'd1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL short_en: en=%b ww=%0d ready=%b we=%b required 1/1/0/0",
                        en, words_written, in_ready, mem_we);
    end
  endtask

  task automatic test_long_imm();
    do_reset(1);
    send(4'd2, 4'd1, 4'd0, 4'd7, 32'h0001_8000, 1'b0, 0);
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_wdata !== 32'hF000_0001 || in_ready !== 1'b0) begin
      fails++; $display("FAIL long_prefix: we=%b addr=%0d data=%h ready=%b required 1/0/F0000001/0",
                        mem_we, mem_addr, mem_wdata, in_ready);
    end
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== 32'h2107_8000) begin
      fails++; $display("FAIL long_main: we=%b addr=%0d data=%h required 1/1/21078000",
                        mem_we, mem_addr, mem_wdata);
    end
    tests++;
    if (in_ready !== 1'b1 || words_written !== 4'd2 || en !== 1'b0) begin
      fails++; $display("FAIL long_back_to_load: ready=%b ww=%0d en=%b required 1/2/0",
                        in_ready, words_written, en);
    end
  endtask

  task automatic test_neg_short();
    do_reset(1);
    send(4'd3, 4'd5, 4'd6, 4'd9, 32'hFFFF_8000, 1'b1, 0);
    repeat (4) @(negedge clk);
    tests++;
    if (mon_data.size() !== 1) begin
      fails++; $display("FAIL neg_short_count: got %0d words required 1", mon_data.size());
    end else begin
      tests++;
      if (mon_data[0] !== 32'h3569_8000) begin
        fails++; $display("FAIL neg_short_data: got %h required 35698000", mon_data[0]);
      end
    end
  endtask

  task automatic test_random();
    int nb, nw;
    bit lng, last;
    logic [31:0] im;
    int nmon;
    bit saw_ready;
    for (int p = 0; p < 15; p++) begin
      do_reset($urandom_range(1, 3));
      nb = $urandom_range(1, 6);
      nw = 0;
      for (int i = 0; i < nb; i++) begin
        lng = ($urandom_range(0, 1) == 1) && (nw + 2 <= DEPTH);
        im = rand_imm(lng);
        nw += long_imm(im) ? 2 : 1;
        last = (i == nb - 1) || (nw >= DEPTH);
        send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), im, last, $urandom_range(0, 2));
        if (last) break;
      end
      repeat (6) @(negedge clk);
      tests++;
      if (mon_addr.size() !== exp_addr.size()) begin
        fails++; $display("FAIL rand_count p%0d: got %0d words required %0d", p, mon_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
        tests++;
        if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i] || mon_cyc[i] !== exp_cyc[i]) begin
          fails++; $display("FAIL rand_word p%0d #%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d",
                            p, i, mon_addr[i], mon_data[i], mon_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
        end
      end
      tests++;
      if (en_cyc !== m_en_cyc) begin
        fails++; $display("FAIL rand_en_cycle p%0d: got %0d required %0d", p, en_cyc, m_en_cyc);
      end
      tests++;
      if (words_written !== m_ww[AW:0] || full !== (m_ww == DEPTH) || ovf !== m_ovf || overlap !== 0) begin
        fails++; $display("FAIL rand_status p%0d: ww=%0d full=%b ovf=%b overlap=%0d required %0d/%b/%b/0",
                          p, words_written, full, ovf, overlap, m_ww, (m_ww == DEPTH), m_ovf);
      end
      // RUN ignores further bundles
      nmon = mon_addr.size();
      saw_ready = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        in_valid = 1'b1; imm = $urandom; opcode = 4'($urandom); in_last = 1'($urandom);
        if (in_ready !== 1'b0) saw_ready = 1;
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (saw_ready || mon_addr.size() !== nmon || en !== 1'b1) begin
        fails++; $display("FAIL run_ignores p%0d: ready_seen=%b words=%0d en=%b required 0/%0d/1",
                          p, saw_ready, mon_addr.size(), en, nmon);
      end
    end
  endtask

  task automatic test_fill();
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) begin
      send((i == 3) ? 4'hF : 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 32'(i * 7), 1'b0, 0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (mon_addr.size() !== DEPTH) begin
      fails++; $display("FAIL fill_count: got %0d words required %0d", mon_addr.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < mon_addr.size(); i++) begin
      tests++;
      if (mon_addr[i] !== i || mon_data[i] !== exp_data[i]) begin
        fails++; $display("FAIL fill_word #%0d: got a=%0d d=%h required a=%0d d=%h",
                          i, mon_addr[i], mon_data[i], i, exp_data[i]);
      end
    end
    tests++;
    if (full !== 1'b1 || in_ready !== 1'b0 || words_written !== 4'(DEPTH) || ovf !== 1'b0 || en !== 1'b0) begin
      fails++; $display("FAIL fill_status: full=%b ready=%b ww=%0d ovf=%b en=%b required 1/0/%0d/0/0",
                        full, in_ready, words_written, ovf, en, DEPTH);
    end
    in_valid = 1'b1; in_last = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (mon_addr.size() !== DEPTH || en !== 1'b0) begin
      fails++; $display("FAIL full_no_wrap: words=%0d en=%b required %0d/0", mon_addr.size(), en, DEPTH);
    end
  endtask

  task automatic test_ovf_drop();
    do_reset(1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      send(4'd1, 4'd1, 4'd1, 4'(i), 32'(i), 1'b0, $urandom_range(0, 1));
    end
    send(4'd6, 4'd2, 4'd3, 4'd4, 32'h8000_0000, 1'b1, 0);
    repeat (4) @(negedge clk);
    tests++;
    if (mon_addr.size() !== DEPTH - 1 || words_written !== 4'(DEPTH - 1)) begin
      fails++; $display("FAIL ovf_no_write: words=%0d ww=%0d required %0d/%0d",
                        mon_addr.size(), words_written, DEPTH - 1, DEPTH - 1);
    end
    tests++;
    if (ovf !== 1'b1 || full !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL ovf_flags: ovf=%b full=%b ready=%b required 1/1/0", ovf, full, in_ready);
    end
    tests++;
    if (en_cyc !== m_en_cyc || en !== 1'b1) begin
      fails++; $display("FAIL ovf_en: en_cycle=%0d en=%b required %0d/1", en_cyc, en, m_en_cyc);
    end
  endtask

  task automatic test_reset_mid_ext();
    do_reset(1);
    send(4'd5, 4'd1, 4'd2, 4'd3, 32'h0012_3456, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({mem_we, en, full, ovf, in_ready} !== 5'b00000 || mem_addr !== '0 || mem_wdata !== 32'h0 ||
        words_written !== '0) begin
      fails++; $display("FAIL midext_reset: flags=%b addr=%0d data=%h ww=%0d required 00000/0/0/0",
                        {mem_we, en, full, ovf, in_ready}, mem_addr, mem_wdata, words_written);
    end
    rst = 1'b0;
    clear_tracking();
    repeat (3) @(negedge clk);
    tests++;
    if (mon_addr.size() !== 0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midext_discard: words=%0d ready=%b required 0/1", mon_addr.size(), in_ready);
    end
    send(4'd8, 4'd7, 4'd6, 4'd5, 32'h0000_0042, 1'b1, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (mon_addr.size() !== 1 || mon_addr[0] !== 0 || mon_data[0] !== 32'h8765_0042) begin
      fails++; $display("FAIL midext_restart: words=%0d a=%0d d=%h required 1/0/87650042",
                        mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : -1,
                        (mon_data.size() > 0) ? mon_data[0] : 32'h0);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset(1);
    send(4'd1, 4'd2, 4'd3, 4'd4, 32'd5, 1'b0, 0);
    send(4'd0, 4'd0, 4'd0, 4'd0, 32'd1, 1'b1, 0);
    repeat (2) @(negedge clk);
    tests++;
    if (checksum !== 32'h1234_0006 || en !== 1'b1) begin
      fails++; $display("FAIL checksum: got %h en=%b required 12340006/1", checksum, en);
    end
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (checksum !== 32'h1234_0006) begin
      fails++; $display("FAIL checksum_frozen: got %h required 12340006", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short_load();
    test_long_imm();
    test_neg_short();
    test_fill();
    test_ovf_drop();
    test_reset_mid_ext();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
